// File: rtl/dmem_bus_bridge.sv
// Bridges single-cycle memory-stage requests onto a valid/ready + response-valid
// data-memory bus, stalling the pipeline until each access completes.
// Optional response timeout: define DMEM_TIMEOUT_EN.
module dmem_bus_bridge #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned WordSize      = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memory_read_enable,
  input  logic                 memory_write_enable,
  input  logic [AddrWidth-1:0] address,
  input  logic [DataWidth-1:0] write_data,
  input  logic [WordSize-1:0]  write_strobe,
  output logic [DataWidth-1:0] read_data,
  output logic                 stall,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_req_write,
  output logic [AddrWidth-1:0] bus_req_addr,
  output logic [DataWidth-1:0] bus_req_wdata,
  output logic [WordSize-1:0]  bus_req_strobe,
  input  logic                 bus_rsp_valid,
  input  logic [DataWidth-1:0] bus_rsp_rdata,
  output logic                 mem_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 valid_q, valid_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [WordSize-1:0]  strobe_q, strobe_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 accept;

  // Requests are always word aligned on the bus; the low address bits only
  // matter to the lane extraction done upstream.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntRaw   = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntWidth = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    rdata_d  = rdata_q;
    accept   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Read wins a collision; a strobe-less write is a no-op.
        if (memory_read_enable || (memory_write_enable && (|write_strobe))) begin
          accept   = 1'b1;
          state_d  = REQ;
          valid_d  = 1'b1;
          write_d  = !memory_read_enable;
          addr_d   = {address[AddrWidth-1:2], 2'b00};
          wdata_d  = write_data;
          strobe_d = memory_read_enable ? '0 : write_strobe;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = WAIT;
          valid_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_d = DONE;
          if (!write_q) begin
            rdata_d = bus_rsp_rdata;
          end
`ifdef DMEM_TIMEOUT_EN
        end else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!write_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Stall must rise in the accept cycle itself, so it cannot be registered.
  assign stall          = accept || (state_q == REQ) || (state_q == WAIT);
  assign read_data      = rdata_q;
  assign bus_req_valid  = valid_q;
  assign bus_req_write  = write_q;
  assign bus_req_addr   = addr_q;
  assign bus_req_wdata  = wdata_q;
  assign bus_req_strobe = strobe_q;

`ifdef DMEM_TIMEOUT_EN
  assign mem_error = err_q;
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed bench for dmem_bus_bridge: inputs change on the falling edge and
// outputs are checked 1 time unit later, mid-cycle.
module tb_dmem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr;
  logic [31:0] address, write_data;
  logic [3:0]  write_strobe;
  logic [31:0] read_data;
  logic        stall;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strobe;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_error;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(
    .DataWidth    (32),
    .AddrWidth    (32),
    .WordSize     (4),
    .TimeoutCycles(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .memory_read_enable (rd),
    .memory_write_enable(wr),
    .address            (address),
    .write_data         (write_data),
    .write_strobe       (write_strobe),
    .read_data          (read_data),
    .stall              (stall),
    .bus_req_valid      (req_valid),
    .bus_req_ready      (req_ready),
    .bus_req_write      (req_write),
    .bus_req_addr       (req_addr),
    .bus_req_wdata      (req_wdata),
    .bus_req_strobe     (req_strobe),
    .bus_rsp_valid      (rsp_valid),
    .bus_rsp_rdata      (rsp_rdata),
    .mem_error          (mem_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0;
    address = '0; write_data = '0; write_strobe = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", req_addr, 32'd0);
    chk("rst_err", {31'b0, mem_error}, 32'd0);
    rst = 1'b1;

    // Load, zero wait states
    @(negedge clk);
    rd = 1'b1; address = 32'h1006; req_ready = 1'b1; rsp_valid = 1'b1; rsp_rdata = 32'h11223344;
    #1;
    chk("ld_acc_stall", {31'b0, stall}, 32'd1);
    chk("ld_acc_valid", {31'b0, req_valid}, 32'd0);
    @(negedge clk); #1;
    chk("ld_req_valid", {31'b0, req_valid}, 32'd1);
    chk("ld_req_addr", req_addr, 32'h1004);
    chk("ld_req_strobe", {28'b0, req_strobe}, 32'd0);
    chk("ld_req_write", {31'b0, req_write}, 32'd0);
    chk("ld_req_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("ld_wait_valid", {31'b0, req_valid}, 32'd0);
    chk("ld_wait_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("ld_done_stall", {31'b0, stall}, 32'd0);
    chk("ld_done_rdata", read_data, 32'h11223344);
    @(negedge clk);
    rd = 1'b0; #1;
    chk("ld_idle_stall", {31'b0, stall}, 32'd0);
    chk("ld_idle_valid", {31'b0, req_valid}, 32'd0);

    // Store with 4 cycles of backpressure
    @(negedge clk);
    wr = 1'b1; address = 32'h2001; write_data = 32'h0000AB00; write_strobe = 4'b0010;
    req_ready = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("st_acc_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("st_bp_valid", {31'b0, req_valid}, 32'd1);
      chk("st_bp_addr", req_addr, 32'h2000);
      chk("st_bp_wdata", req_wdata, 32'h0000AB00);
      chk("st_bp_strobe", {28'b0, req_strobe}, 32'd2);
      chk("st_bp_write", {31'b0, req_write}, 32'd1);
      chk("st_bp_stall", {31'b0, stall}, 32'd1);
    end
    @(negedge clk);
    req_ready = 1'b1; #1;
    chk("st_hs_valid", {31'b0, req_valid}, 32'd1);
    @(negedge clk);
    req_ready = 1'b0; rsp_valid = 1'b1; #1;
    chk("st_wait_valid", {31'b0, req_valid}, 32'd0);
    chk("st_wait_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rsp_valid = 1'b0; #1;
    chk("st_done_stall", {31'b0, stall}, 32'd0);
    chk("st_done_rdata", read_data, 32'h11223344);
    @(negedge clk);
    wr = 1'b0; #1;
    chk("st_idle_valid", {31'b0, req_valid}, 32'd0);

    // Zero-strobe write is a no-op
    @(negedge clk);
    wr = 1'b1; write_strobe = 4'b0000; address = 32'h2100; #1;
    chk("zs_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("zs_valid", {31'b0, req_valid}, 32'd0);
    chk("zs_stall2", {31'b0, stall}, 32'd0);

    // Read/write collision: read wins
    @(negedge clk);
    rd = 1'b1; wr = 1'b1; write_strobe = 4'hF; address = 32'h3000; req_ready = 1'b1; #1;
    chk("col_acc_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("col_valid", {31'b0, req_valid}, 32'd1);
    chk("col_write", {31'b0, req_write}, 32'd0);
    chk("col_strobe", {28'b0, req_strobe}, 32'd0);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'h55667788; #1;
    chk("col_wait_valid", {31'b0, req_valid}, 32'd0);
    @(negedge clk);
    rsp_valid = 1'b0; #1;
    chk("col_done_rdata", read_data, 32'h55667788);
    chk("col_done_stall", {31'b0, stall}, 32'd0);
    rd = 1'b0; wr = 1'b0; write_strobe = 4'h0;

    // Back-to-back loads, response delayed 2 cycles each
    @(negedge clk);
    rd = 1'b1; address = 32'h10; #1;
    chk("b2b1_acc_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("b2b1_valid", {31'b0, req_valid}, 32'd1);
    chk("b2b1_addr", req_addr, 32'h10);
    @(negedge clk); #1;
    chk("b2b1_w0_valid", {31'b0, req_valid}, 32'd0);
    @(negedge clk); #1;
    chk("b2b1_w1_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'hA0A0A0A0; #1;
    chk("b2b1_w2_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rsp_valid = 1'b0; address = 32'h14; #1;
    chk("b2b1_done_rdata", read_data, 32'hA0A0A0A0);
    chk("b2b1_done_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("b2b2_nodup_valid", {31'b0, req_valid}, 32'd0);
    chk("b2b2_acc_stall", {31'b0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("b2b2_valid", {31'b0, req_valid}, 32'd1);
    chk("b2b2_addr", req_addr, 32'h14);
    @(negedge clk); #1;
    chk("b2b2_w0_valid", {31'b0, req_valid}, 32'd0);
    @(negedge clk); #1;
    chk("b2b2_w1_rdata", read_data, 32'hA0A0A0A0);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'h14141414; #1;
    @(negedge clk);
    rsp_valid = 1'b0; rd = 1'b0; #1;
    chk("b2b2_done_rdata", read_data, 32'h14141414);
    chk("b2b2_done_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("b2b2_idle_valid", {31'b0, req_valid}, 32'd0);
    chk("b2b2_idle_stall", {31'b0, stall}, 32'd0);

    // Reset asserted mid-WAIT abandons the access
    @(negedge clk);
    rd = 1'b1; address = 32'h40; #1;
    @(negedge clk); #1;
    chk("rw_req_valid", {31'b0, req_valid}, 32'd1);
    @(negedge clk); #1;
    chk("rw_wait_stall", {31'b0, stall}, 32'd1);
    rst = 1'b0; rd = 1'b0; #1;
    chk("rw_valid", {31'b0, req_valid}, 32'd0);
    chk("rw_stall", {31'b0, stall}, 32'd0);
    chk("rw_rdata", read_data, 32'd0);
    chk("rw_addr", req_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    rsp_valid = 1'b0; #1;
    chk("rw_late_rdata", read_data, 32'd0);
    chk("rw_late_valid", {31'b0, req_valid}, 32'd0);
    chk("rw_late_stall", {31'b0, stall}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Response on the eighth WAIT cycle completes normally
    @(negedge clk);
    rd = 1'b1; address = 32'h80; req_ready = 1'b1; #1;
    @(negedge clk); #1;
    chk("to_a_valid", {31'b0, req_valid}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      chk("to_a_wait_stall", {31'b0, stall}, 32'd1);
      chk("to_a_wait_err", {31'b0, mem_error}, 32'd0);
    end
    @(negedge clk);
    rsp_valid = 1'b1; rsp_rdata = 32'h88888888; #1;
    chk("to_a_last_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    rsp_valid = 1'b0; rd = 1'b0; #1;
    chk("to_a_done_err", {31'b0, mem_error}, 32'd0);
    chk("to_a_done_rdata", read_data, 32'h88888888);
    chk("to_a_done_stall", {31'b0, stall}, 32'd0);

    // No response: timeout after 8 WAIT cycles
    @(negedge clk);
    rd = 1'b1; address = 32'h84; #1;
    @(negedge clk); #1;
    chk("to_b_valid", {31'b0, req_valid}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("to_b_wait_stall", {31'b0, stall}, 32'd1);
      chk("to_b_wait_err", {31'b0, mem_error}, 32'd0);
    end
    @(negedge clk);
    rd = 1'b0; #1;
    chk("to_b_done_err", {31'b0, mem_error}, 32'd1);
    chk("to_b_done_rdata", read_data, 32'd0);
    chk("to_b_done_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("to_b_idle_err", {31'b0, mem_error}, 32'd0);
`else
    chk("noto_err", {31'b0, mem_error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
